eeg_wram_rd_ctrl: RTL and testbench

Read-side sequencer for the 4-bank weight RAM during convolution. It accepts one read command (base, stride, length, bank mask) and generates a per-bank address stream with VLD/LST/RDY handshakes. It bounds outstanding reads per bank by counting returned data beats and pulses DONE once every enabled bank has returned its last beat. It sits between the CONV engine's config path and the WRAM ETOW_ADD/WTOE_DAT ports.

---
 rtl/eeg_pkg.sv | 22 ++
 rtl/eeg_wram_rd_lane.sv | 118 +++++++++++
 rtl/eeg_wram_rd_ctrl.sv | 123 ++++++++++++
 tb/tb_eeg_wram_rd_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_pkg.sv
// ---------------------------------------------------------------------------
// eeg_pkg
// Shared definitions for the weight-RAM read sequencer: default bank count,
// widths and outstanding-read limit, plus the one-hot read FSM encoding.
// No ports.
// ---------------------------------------------------------------------------
package eeg_pkg;

  localparam int WRAM_NUM_DW_DEF  = 4;   // number of WRAM banks
  localparam int WRAM_ADD_AW_DEF  = 13;  // bank address width
  localparam int WRAM_LEN_DW_DEF  = 13;  // beats-per-bank field width
  localparam int WRAM_OTS_MAX_DEF = 4;   // outstanding reads per bank, >= 1

  // One-hot so each output decode is a single flop bit.
  typedef enum logic [3:0] {
    RD_IDLE  = 4'b0001,
    RD_ISSUE = 4'b0010,
    RD_DRAIN = 4'b0100,
    RD_DONE  = 4'b1000
  } rd_state_e;

endpackage

// File: rtl/eeg_wram_rd_lane.sv
// ---------------------------------------------------------------------------
// eeg_wram_rd_lane
// One bank's read-address generator. Holds the beat index, the running
// address accumulator, the outstanding-read counter and the sticky
// issued/done flags for the current command.
//
// Ports
//   clk, rst        clock, async active-high reset
//   start           command accept pulse (reloads all lane state)
//   en              bank enable bit of the command being accepted
//   issue, active   top FSM is in ISSUE / in ISSUE or DRAIN
//   base, strd      first address (sampled on start) and per-beat increment
//   len_m1          beats per bank minus one
//   add_vld/lst/add address stream to the bank, add_rdy from the bank
//   dat_vld/rdy/lst observed data-return handshake of the bank
//   issued_all      this lane has nothing left to issue (includes this cycle)
//   done_all        this lane has seen its last data beat (includes this cycle)
// ---------------------------------------------------------------------------
module eeg_wram_rd_lane
  import eeg_pkg::*;
#(
  parameter int ADD_AW  = WRAM_ADD_AW_DEF,
  parameter int LEN_DW  = WRAM_LEN_DW_DEF,
  parameter int OTS_MAX = WRAM_OTS_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic              issue,
  input  logic              active,
  input  logic [ADD_AW-1:0] base,
  input  logic [ADD_AW-1:0] strd,
  input  logic [LEN_DW-1:0] len_m1,
  input  logic              add_rdy,
  input  logic              dat_vld,
  input  logic              dat_rdy,
  input  logic              dat_lst,
  output logic              add_vld,
  output logic              add_lst,
  output logic [ADD_AW-1:0] add_add,
  output logic              issued_all,
  output logic              done_all
);

  localparam int OTS_W = $clog2(OTS_MAX + 1);

  logic              en_q, en_d;
  logic [LEN_DW-1:0] idx_q, idx_d;
  logic [ADD_AW-1:0] addr_q, addr_d;
  logic [OTS_W-1:0]  ots_q, ots_d;
  logic              issued_q, issued_d;
  logic              done_q, done_d;

  logic add_hs, dat_hs, dat_dec, lst_beat;

  always_comb begin
    add_vld  = issue & en_q & ~issued_q & (ots_q < OTS_W'(OTS_MAX));
    add_lst  = add_vld & (idx_q == len_m1);
    add_add  = addr_q;
    add_hs   = add_vld & add_rdy;
    dat_hs   = active & en_q & dat_vld & dat_rdy;
    dat_dec  = dat_hs & (ots_q != '0);
    lst_beat = dat_hs & dat_lst;

    // Fold in the current-cycle event so the FSM advances one cycle earlier.
    issued_all = issued_q | (add_hs & add_lst);
    done_all   = done_q | lst_beat;

    en_d     = en_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    ots_d    = ots_q;
    issued_d = issued_q;
    done_d   = done_q;

    if (start) begin
      // A disabled bank is complete from the start for both conditions.
      en_d     = en;
      idx_d    = '0;
      addr_d   = base;
      ots_d    = '0;
      issued_d = ~en;
      done_d   = ~en;
    end else begin
      if (add_hs) begin
        idx_d  = idx_q + LEN_DW'(1);
        addr_d = addr_q + strd;
        if (add_lst) issued_d = 1'b1;
      end
      case ({add_hs, dat_dec})
        2'b10:   ots_d = ots_q + OTS_W'(1);
        2'b01:   ots_d = ots_q - OTS_W'(1);
        default: ots_d = ots_q;
      endcase
      if (lst_beat) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      idx_q    <= '0;
      addr_q   <= '0;
      ots_q    <= '0;
      issued_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      ots_q    <= ots_d;
      issued_q <= issued_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: rtl/eeg_wram_rd_ctrl.sv
// ---------------------------------------------------------------------------
// eeg_wram_rd_ctrl
// Read-side sequencer for the multi-bank weight RAM. Accepts one read
// command, drives an independent address stream per enabled bank, limits
// outstanding reads per bank and pulses DONE once every enabled bank has
// returned its last data beat.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RD_IDLE  | waiting for a command, CMD_RDY high
//   RD_ISSUE | lanes issuing addresses
//   RD_DRAIN | all addresses issued, waiting for last data beats
//   RD_DONE  | one-cycle completion pulse
//
// Ports
//   clk, rst                       clock, async active-high reset
//   CMD_VLD/RDY/BASE/STRD/LEN/MASK read command handshake and fields
//   ADD_VLD/LST/RDY/ADD            per-bank address stream
//   DAT_VLD/RDY/LST                observed per-bank data return
//   BUSY, DONE                     status
// ---------------------------------------------------------------------------
module eeg_wram_rd_ctrl
  import eeg_pkg::*;
#(
  parameter int WRAM_NUM_DW  = WRAM_NUM_DW_DEF,
  parameter int WRAM_ADD_AW  = WRAM_ADD_AW_DEF,
  parameter int WRAM_LEN_DW  = WRAM_LEN_DW_DEF,
  parameter int WRAM_OTS_MAX = WRAM_OTS_MAX_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    CMD_VLD,
  output logic                                    CMD_RDY,
  input  logic [WRAM_ADD_AW-1:0]                  CMD_BASE,
  input  logic [WRAM_ADD_AW-1:0]                  CMD_STRD,
  input  logic [WRAM_LEN_DW-1:0]                  CMD_LEN,
  input  logic [WRAM_NUM_DW-1:0]                  CMD_MASK,
  output logic [WRAM_NUM_DW-1:0]                  ADD_VLD,
  output logic [WRAM_NUM_DW-1:0]                  ADD_LST,
  input  logic [WRAM_NUM_DW-1:0]                  ADD_RDY,
  output logic [WRAM_NUM_DW-1:0][WRAM_ADD_AW-1:0] ADD_ADD,
  input  logic [WRAM_NUM_DW-1:0]                  DAT_VLD,
  input  logic [WRAM_NUM_DW-1:0]                  DAT_RDY,
  input  logic [WRAM_NUM_DW-1:0]                  DAT_LST,
  output logic                                    BUSY,
  output logic                                    DONE
);

  rd_state_e              state_q, state_d;
  logic [WRAM_ADD_AW-1:0] strd_q, strd_d;
  logic [WRAM_LEN_DW-1:0] len_m1_q, len_m1_d;

  logic                   accept, in_issue, in_active;
  logic [WRAM_NUM_DW-1:0] issued_all, done_all;

  assign CMD_RDY   = (state_q == RD_IDLE);
  assign BUSY      = (state_q != RD_IDLE);
  assign DONE      = (state_q == RD_DONE);
  assign accept    = CMD_VLD & CMD_RDY;
  assign in_issue  = (state_q == RD_ISSUE);
  assign in_active = (state_q == RD_ISSUE) | (state_q == RD_DRAIN);

  always_comb begin
    state_d  = state_q;
    strd_d   = strd_q;
    len_m1_d = len_m1_q;
    case (state_q)
      RD_IDLE: begin
        if (CMD_VLD) begin
          strd_d   = CMD_STRD;
          len_m1_d = CMD_LEN - WRAM_LEN_DW'(1);
          // Empty commands skip straight to the completion pulse.
          if ((CMD_LEN == '0) || (CMD_MASK == '0)) state_d = RD_DONE;
          else                                     state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: if (&issued_all) state_d = RD_DRAIN;
      RD_DRAIN: if (&done_all)   state_d = RD_DONE;
      RD_DONE:  state_d = RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RD_IDLE;
      strd_q   <= '0;
      len_m1_q <= '0;
    end else begin
      state_q  <= state_d;
      strd_q   <= strd_d;
      len_m1_q <= len_m1_d;
    end
  end

  for (genvar b = 0; b < WRAM_NUM_DW; b++) begin : g_lane
    eeg_wram_rd_lane #(
      .ADD_AW  (WRAM_ADD_AW),
      .LEN_DW  (WRAM_LEN_DW),
      .OTS_MAX (WRAM_OTS_MAX)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .start      (accept),
      .en         (CMD_MASK[b]),
      .issue      (in_issue),
      .active     (in_active),
      .base       (CMD_BASE),
      .strd       (strd_q),
      .len_m1     (len_m1_q),
      .add_rdy    (ADD_RDY[b]),
      .dat_vld    (DAT_VLD[b]),
      .dat_rdy    (DAT_RDY[b]),
      .dat_lst    (DAT_LST[b]),
      .add_vld    (ADD_VLD[b]),
      .add_lst    (ADD_LST[b]),
      .add_add    (ADD_ADD[b]),
      .issued_all (issued_all[b]),
      .done_all   (done_all[b])
    );
  end

endmodule

// File: tb/tb_eeg_wram_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eeg_wram_rd_ctrl
// Scoreboard bench: each command pushes its expected per-bank address stream
// and a DONE token; a monitor pops/compares on every address handshake and
// DONE. A small memory model returns one data beat LAT cycles after each
// accepted address.
// ---------------------------------------------------------------------------
module tb_eeg_wram_rd_ctrl;
  localparam int NB  = 4;
  localparam int AW  = 13;
  localparam int LW  = 13;
  localparam int LAT = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   CMD_VLD, CMD_RDY;
  logic [AW-1:0]          CMD_BASE, CMD_STRD;
  logic [LW-1:0]          CMD_LEN;
  logic [NB-1:0]          CMD_MASK;
  logic [NB-1:0]          ADD_VLD, ADD_LST, ADD_RDY;
  logic [NB-1:0][AW-1:0]  ADD_ADD;
  logic [NB-1:0]          DAT_VLD, DAT_RDY, DAT_LST;
  logic                   BUSY, DONE;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [AW-1:0] exp_add [NB][$];
  bit            exp_lst [NB][$];
  int            done_tok[$];
  int            mq_rdy  [NB][$];
  bit            mq_lst  [NB][$];

  int            acc_cnt  [NB];
  int            first_acc[NB];
  int            last_acc [NB];
  int            dat_cnt  [NB];
  logic [AW-1:0] log0[$];
  int            last_dat_cyc, last_dat_bank;
  int            acc_cyc, done_cyc;

  eeg_wram_rd_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .CMD_VLD  (CMD_VLD),
    .CMD_RDY  (CMD_RDY),
    .CMD_BASE (CMD_BASE),
    .CMD_STRD (CMD_STRD),
    .CMD_LEN  (CMD_LEN),
    .CMD_MASK (CMD_MASK),
    .ADD_VLD  (ADD_VLD),
    .ADD_LST  (ADD_LST),
    .ADD_RDY  (ADD_RDY),
    .ADD_ADD  (ADD_ADD),
    .DAT_VLD  (DAT_VLD),
    .DAT_RDY  (DAT_RDY),
    .DAT_LST  (DAT_LST),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event not observed within its cycle budget", name);
  endtask

  // Monitor: address scoreboard and DONE tokens.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        if (ADD_VLD[b]) begin
          if (exp_add[b].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_add_vld bank%0d: got ADD_VLD=1 addr=0x%0h, expected ADD_VLD=0",
                     b, ADD_ADD[b]);
          end else if (ADD_RDY[b]) begin
            chk($sformatf("add_addr_b%0d", b), 32'(ADD_ADD[b]), 32'(exp_add[b][0]));
            chk($sformatf("add_lst_b%0d", b), 32'(ADD_LST[b]), 32'(exp_lst[b][0]));
            void'(exp_add[b].pop_front());
            void'(exp_lst[b].pop_front());
            acc_cnt[b]++;
            if (first_acc[b] < 0) first_acc[b] = cyc;
            last_acc[b] = cyc;
            if (b == 0) log0.push_back(ADD_ADD[b]);
          end
        end
      end
      if (DONE) begin
        if (done_tok.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got DONE=1, expected DONE=0");
        end else begin
          void'(done_tok.pop_front());
          chk("busy_with_done", 32'(BUSY), 32'd1);
        end
      end
    end
  end

  // Memory model: one beat per accepted address, LAT cycles later.
  initial begin
    DAT_VLD = '0;
    DAT_LST = '0;
    forever begin
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
        if (rst) begin
          mq_rdy[b].delete();
          mq_lst[b].delete();
        end else begin
          if (DAT_VLD[b] && DAT_RDY[b] && mq_rdy[b].size() > 0) begin
            dat_cnt[b]++;
            if (mq_lst[b][0]) begin
              last_dat_cyc  = cyc;
              last_dat_bank = b;
            end
            void'(mq_rdy[b].pop_front());
            void'(mq_lst[b].pop_front());
          end
          if (ADD_VLD[b] && ADD_RDY[b]) begin
            mq_rdy[b].push_back(cyc + LAT);
            mq_lst[b].push_back(ADD_LST[b]);
          end
        end
      end
      @(posedge clk);
      #1;
      for (int b = 0; b < NB; b++) begin
        if (mq_rdy[b].size() > 0 && mq_rdy[b][0] <= cyc) begin
          DAT_VLD[b] = 1'b1;
          DAT_LST[b] = mq_lst[b][0];
        end else begin
          DAT_VLD[b] = 1'b0;
          DAT_LST[b] = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    for (int b = 0; b < NB; b++) begin
      acc_cnt[b]   = 0;
      first_acc[b] = -1;
      last_acc[b]  = -1;
      dat_cnt[b]   = 0;
    end
    log0.delete();
    last_dat_cyc  = -1;
    last_dat_bank = -1;
  endtask

  task automatic send(input logic [AW-1:0] base, input logic [AW-1:0] strd,
                      input logic [LW-1:0] len, input logic [NB-1:0] mask);
    bit ok = 0;
    clear_logs();
    if (len != 0 && mask != 0) begin
      for (int b = 0; b < NB; b++) begin
        if (mask[b]) begin
          for (int i = 0; i < int'(len); i++) begin
            exp_add[b].push_back(AW'(int'(base) + i * int'(strd)));
            exp_lst[b].push_back(i == int'(len) - 1);
          end
        end
      end
    end
    done_tok.push_back(1);
    @(posedge clk);
    #1;
    CMD_VLD  = 1'b1;
    CMD_BASE = base;
    CMD_STRD = strd;
    CMD_LEN  = len;
    CMD_MASK = mask;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (CMD_RDY) begin
        ok = 1;
        acc_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    CMD_VLD = 1'b0;
    if (!ok) bad("cmd_accept");
  endtask

  task automatic wait_done(input int budget, input string name);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (DONE) begin
        ok = 1;
        done_cyc = cyc;
        break;
      end
    end
    if (!ok) bad(name);
    for (int b = 0; b < NB; b++)
      chk($sformatf("%s_drained_b%0d", name, b), 32'(exp_add[b].size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_rdy"}, 32'(CMD_RDY), 32'd1);
    chk({tag, "_add_vld"}, 32'(ADD_VLD), 32'd0);
    chk({tag, "_add_lst"}, 32'(ADD_LST), 32'd0);
    chk({tag, "_add_add"}, 32'(ADD_ADD), 32'd0);
    chk({tag, "_busy"},    32'(BUSY),    32'd0);
    chk({tag, "_done"},    32'(DONE),    32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    CMD_VLD  = 1'b0;
    CMD_BASE = '0;
    CMD_STRD = '0;
    CMD_LEN  = '0;
    CMD_MASK = '0;
    ADD_RDY  = '1;
    DAT_RDY  = '1;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // 1: single bank, stride 1, three beats.
    send(13'h010, 13'd1, 13'd3, 4'b0001);
    wait_done(60, "t1_done");
    chk("t1_first_add_latency", 32'(first_acc[0]), 32'(acc_cyc + 1));
    chk("t1_n_addr", 32'(log0.size()), 32'd3);
    chk("t1_addr0", 32'(log0[0]), 32'h010);
    chk("t1_addr1", 32'(log0[1]), 32'h011);
    chk("t1_addr2", 32'(log0[2]), 32'h012);
    chk("t1_done_after_last_beat", 32'(done_cyc), 32'(last_dat_cyc + 1));
    @(negedge clk);
    chk("t1_cmd_rdy_after_done", 32'(CMD_RDY), 32'd1);
    chk("t1_done_one_cycle", 32'(DONE), 32'd0);

    // 2: outstanding limit with data held off, then release.
    DAT_RDY = '0;
    send(13'h000, 13'd1, 13'd8, 4'b1111);
    repeat (20) @(negedge clk);
    for (int b = 0; b < NB; b++)
      chk($sformatf("t2_ots_cap_b%0d", b), 32'(acc_cnt[b]), 32'd4);
    chk("t2_add_vld_blocked", 32'(ADD_VLD), 32'd0);
    chk("t2_busy", 32'(BUSY), 32'd1);
    @(posedge clk);
    #1;
    DAT_RDY = '1;
    wait_done(200, "t2_done");
    for (int b = 0; b < NB; b++)
      chk($sformatf("t2_beats_b%0d", b), 32'(dat_cnt[b]), 32'd8);
    chk("t2_done_after_last_beat", 32'(done_cyc), 32'(last_dat_cyc + 1));

    // 3: 13-bit address wrap.
    send(13'h1FFE, 13'd3, 13'd3, 4'b0001);
    wait_done(60, "t3_done");
    chk("t3_addr0", 32'(log0[0]), 32'h1FFE);
    chk("t3_addr1", 32'(log0[1]), 32'h0001);
    chk("t3_addr2", 32'(log0[2]), 32'h0004);

    // 4: empty commands pulse DONE in the cycle after the accept cycle.
    send(13'h000, 13'd1, 13'd0, 4'b1111);
    wait_done(20, "t4a_done");
    chk("t4a_done_latency", 32'(done_cyc), 32'(acc_cyc + 1));
    @(negedge clk);
    chk("t4a_done_one_cycle", 32'(DONE), 32'd0);
    send(13'h000, 13'd1, 13'd5, 4'b0000);
    wait_done(20, "t4b_done");
    chk("t4b_done_latency", 32'(done_cyc), 32'(acc_cyc + 1));

    // 5: banks 0 and 2, bank 2 address path stalled for ~10 cycles.
    ADD_RDY = 4'b1011;
    send(13'h040, 13'd2, 13'd4, 4'b0101);
    repeat (9) @(posedge clk);
    #1;
    ADD_RDY = '1;
    wait_done(100, "t5_done");
    chk("t5_bank0_before_bank2", 32'(last_acc[0] < first_acc[2]), 32'd1);
    chk("t5_bank1_idle", 32'(acc_cnt[1]), 32'd0);
    chk("t5_bank3_idle", 32'(acc_cnt[3]), 32'd0);
    chk("t5_last_beat_bank", 32'(last_dat_bank), 32'd2);
    chk("t5_done_after_bank2", 32'(done_cyc), 32'(last_dat_cyc + 1));

    // 6: reset in the middle of ISSUE, then a fresh command.
    send(13'h100, 13'd1, 13'd6, 4'b0001);
    for (int k = 0; k < 20; k++) begin
      if (acc_cnt[0] >= 2) break;
      @(posedge clk);
      #1;
    end
    chk("t6_two_beats_before_rst", 32'(acc_cnt[0]), 32'd2);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    for (int b = 0; b < NB; b++) begin
      exp_add[b].delete();
      exp_lst[b].delete();
    end
    done_tok.delete();
    repeat (3) @(negedge clk);
    chk("t6_no_done_in_rst", 32'(DONE), 32'd0);
    rst = 1'b0;
    DAT_RDY = '0;
    send(13'h100, 13'd1, 13'd6, 4'b0001);
    repeat (15) @(negedge clk);
    chk("t6_ots_cleared", 32'(acc_cnt[0]), 32'd4);
    chk("t6_restart_base", 32'(log0[0]), 32'h100);
    @(posedge clk);
    #1;
    DAT_RDY = '1;
    wait_done(100, "t6_done");
    chk("t6_beats", 32'(dat_cnt[0]), 32'd6);

    repeat (5) @(negedge clk);
    chk("end_tokens_empty", 32'(done_tok.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
